ysyx_25010008_fetch_ctrl: RTL and testbench
===========================================

# ysyx_25010008_fetch_ctrl

Front-end fetch controller of the ysyx_25010008 pipeline. It owns the architectural fetch PC, issues one-at-a-time instruction-memory requests, buffers returned instructions in a 2-entry queue toward the decode stage, and consumes the execute stage's misprediction report (`is_wrong_prediction` / `exu_npc`). From that report it redirects fetch and drives `clear_pipeline` back to the execute and decode stages. Static prediction is always PC+4.

## Interface
- `RESET_PC`, 32'h8000_0000: first fetch address after reset.
- `clock`  in  1  sole clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `imem_req_valid`  out  1  fetch request valid.
- `imem_req_ready`  in  1  memory accepts request.
- `imem_req_addr`  out  32  fetch address, word-aligned, stable while `valid && !ready`.
- `imem_rsp_valid`  in  1  instruction return, single-cycle pulse, never stalled.
- `imem_rsp_data`  in  32  returned instruction.
- `fetch_valid`  out  1  instruction available to decode.
- `fetch_ready`  in  1  decode consumes (low while pipeline `block`).
- `fetch_pc`  out  32  PC of the head instruction.
- `fetch_inst`  out  32  head instruction.
- `exu_redirect`  in  1  misprediction flag from execute (`is_wrong_prediction`).
- `exu_npc`  in  32  correct next PC from execute.
- `clear_pipeline`  out  1  flush to decode/execute.

## Operation
- State machine `IDLE`, `REQ`, `WAIT`; a `discard` flag; `pc` register; 2-entry FIFO of {pc, inst}.
- `IDLE`: go to `REQ` when FIFO count < 2.
- `REQ`: `imem_req_valid`=1, `imem_req_addr`=`pc`. On `imem_req_ready`: capture `req_pc`=`pc`, `pc`<=`pc`+4 (mod 2^32), go to `WAIT`.
- `WAIT`: on `imem_rsp_valid`: if `discard`, drop the data and clear `discard`; else push {`req_pc`, data}. Next state `REQ` if post-edge FIFO count < 2, else `IDLE`.
- FIFO pop on `fetch_valid && fetch_ready`; push and pop in the same cycle both take effect.
- Redirect (`exu_redirect`=1), all same-cycle effects:
  - `clear_pipeline` = `exu_redirect`, combinational;
  - FIFO flushed; any pop that cycle is ignored;
  - `pc` <= {`exu_npc`[31:2], 2'b00};
  - in `WAIT` with no response this cycle: `discard` set;
  - in `WAIT` with a response this cycle: that response is dropped and `discard` stays clear;
  - in `REQ` and not accepted: the request is held unchanged, `discard` is set on acceptance, and the new `pc` is used for the following request;
  - in `REQ` and accepted: treated as `WAIT` with `discard` set;
  - `IDLE`: go to `REQ`.
- Redirect wins over any push or pop in the same cycle. Redirect to the current `pc` value is still a full flush.

## Timing
- Reset values: `imem_req_valid`=0, `fetch_valid`=0, `fetch_pc`=0, `fetch_inst`=0, state `IDLE`, `discard`=0, `pc`=`RESET_PC`, FIFO empty. `clear_pipeline` follows `exu_redirect` even in reset.
- First `imem_req_valid` in the first cycle after reset deasserts.
- At most one outstanding request.
- Response to `fetch_valid`: next cycle (bypass off).
- Redirect to first request at the new PC, with no outstanding request: next cycle.
- Back-to-back fetch with a 1-cycle memory: one instruction every 2 cycles.
- Reset asserted mid-transaction: all state cleared immediately. Any later response is ignored because the state is not `WAIT`.

## Configuration
- `YSYX_25010008_FETCH_BYPASS_EN` defined:
  - when the FIFO is empty and a non-discarded response arrives, `fetch_valid`/`fetch_pc`/`fetch_inst` present it combinationally in the same cycle;
  - if `fetch_ready`=1 it is not pushed; otherwise it is pushed.
- Undefined: every instruction passes through the FIFO (one extra cycle), and outputs are purely registered-FIFO driven.

## Test plan
- Reset release, memory always ready with 1-cycle latency: requests at 0x80000000, 0x80000004, 0x80000008 in order; decode sees matching `fetch_pc`/`fetch_inst` pairs.
- `fetch_ready`=0 held: after 2 instructions are queued, `imem_req_valid` stays 0. Raising `fetch_ready` for one cycle yields exactly one new request.
- `exu_redirect`=1, `exu_npc`=0x80000103 while in `WAIT`: `clear_pipeline` pulses in the same cycle and `fetch_valid` drops next cycle. The in-flight response (inst 0xDEADBEEF) is never presented. Next request address is 0x80000100.
- Redirect coinciding with `imem_rsp_valid`: response dropped, `discard` stays 0, and the next response is delivered normally.
- Redirect while `imem_req_ready`=0 for 3 cycles: `imem_req_addr` stays constant until acceptance. Its response is dropped, then the request at the new PC is issued.
- Reset asserted during `WAIT`, then a late `imem_rsp_valid` arrives: `fetch_valid` stays 0 and the first post-reset request is at `RESET_PC`.
- With bypass defined, empty FIFO, `fetch_ready`=1: `fetch_valid` is asserted in the same cycle as `imem_rsp_valid`.

Source files
------------

// File: rtl/ysyx_25010008_fetch_ctrl.sv
// Fetch controller: owns the fetch PC, issues one-outstanding imem requests, queues {pc, inst} for decode.
// Optional `YSYX_25010008_FETCH_BYPASS_EN: an empty-queue response reaches decode in its arrival cycle.
module ysyx_25010008_fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
    input  logic        clock,
    input  logic        reset,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        fetch_valid,
    input  logic        fetch_ready,
    output logic [31:0] fetch_pc,
    output logic [31:0] fetch_inst,
    input  logic        exu_redirect,
    input  logic [31:0] exu_npc,
    output logic        clear_pipeline
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } state_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } entry_t;

    localparam int unsigned DEPTH = 2;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] req_addr_q, req_addr_d;
    logic [31:0] req_pc_q, req_pc_d;
    logic        discard_q, discard_d;
    logic        req_valid_q;
    logic        head_q, head_d;
    logic [1:0]  count_q, count_d;
    entry_t      fifo_q [DEPTH];
    entry_t      fifo_d [DEPTH];

    logic        rsp_take;
    logic        bypass_hit;
    logic        push;
    logic        pop;
    logic        wr_idx;
    logic [31:0] redirect_pc;

    assign clear_pipeline = exu_redirect;
    assign redirect_pc    = {exu_npc[31:2], 2'b00};
    assign imem_req_valid = req_valid_q;
    assign imem_req_addr  = req_addr_q;

    // A response is kept only if it belongs to the current PC stream.
    assign rsp_take = (state_q == WAIT) && imem_rsp_valid && !discard_q && !exu_redirect;

`ifdef YSYX_25010008_FETCH_BYPASS_EN
    assign bypass_hit  = rsp_take && (count_q == 2'd0);
    assign push        = rsp_take && !(bypass_hit && fetch_ready);
    assign fetch_valid = (count_q != 2'd0) || bypass_hit;
    assign fetch_pc    = bypass_hit ? req_pc_q : fifo_q[head_q].pc;
    assign fetch_inst  = bypass_hit ? imem_rsp_data : fifo_q[head_q].inst;
`else
    assign bypass_hit  = 1'b0;
    assign push        = rsp_take;
    assign fetch_valid = (count_q != 2'd0);
    assign fetch_pc    = fifo_q[head_q].pc;
    assign fetch_inst  = fifo_q[head_q].inst;
`endif

    assign pop    = fetch_ready && (count_q != 2'd0) && !exu_redirect;
    assign wr_idx = head_q ^ count_q[0];

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        fifo_d  = fifo_q;
        head_d  = head_q;
        count_d = count_q;
        if (exu_redirect) begin
            count_d = 2'd0;
        end else begin
            if (push) begin
                fifo_d[wr_idx] = '{pc: req_pc_q, inst: imem_rsp_data};
            end
            if (pop) begin
                head_d = ~head_q;
            end
            count_d = count_q + {1'b0, push} - {1'b0, pop};
        end
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        req_addr_d = req_addr_q;
        req_pc_d   = req_pc_q;
        discard_d  = discard_q;

        unique case (state_q)
            IDLE: begin
                if (exu_redirect || (count_q < 2'd2)) begin
                    state_d = REQ;
                end
            end
            REQ: begin
                // discard_q set here means a redirect arrived while the request was held.
                if (exu_redirect) begin
                    discard_d = 1'b1;
                end
                if (imem_req_ready) begin
                    req_pc_d = req_addr_q;
                    state_d  = WAIT;
                    if (!discard_q) begin
                        pc_d = pc_q + 32'd4;
                    end
                end
            end
            WAIT: begin
                if (imem_rsp_valid) begin
                    discard_d = 1'b0;
                    state_d   = (count_d < 2'd2) ? REQ : IDLE;
                end else if (exu_redirect) begin
                    discard_d = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (exu_redirect) begin
            pc_d = redirect_pc;
        end

        // The request address is frozen on entry to REQ so a held request never changes.
        if ((state_d == REQ) && (state_q != REQ)) begin
            req_addr_d = pc_d;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            pc_q        <= RESET_PC;
            req_addr_q  <= RESET_PC;
            req_pc_q    <= '0;
            discard_q   <= 1'b0;
            req_valid_q <= 1'b0;
            head_q      <= 1'b0;
            count_q     <= 2'd0;
            // NOTE: the queue storage is reset because fetch_pc/fetch_inst read it directly and must be 0 in reset.
            for (int i = 0; i < DEPTH; i++) begin
                fifo_q[i] <= '0;
            end
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
            state_q     <= state_d;
            pc_q        <= pc_d;
            req_addr_q  <= req_addr_d;
            req_pc_q    <= req_pc_d;
            discard_q   <= discard_d;
            req_valid_q <= (state_d == REQ);
            head_q      <= head_d;
            count_q     <= count_d;
            fifo_q      <= fifo_d;
        end
    end

    a_req_stable : assert property (@(posedge clock) disable iff (!reset)
        (imem_req_valid && !imem_req_ready) |=> (imem_req_valid && $stable(imem_req_addr)));

    a_no_overflow : assert property (@(posedge clock) disable iff (!reset)
        !(push && !pop && (count_q == 2'd2)));

    a_bypass_only_empty : assert property (@(posedge clock) disable iff (!reset)
        bypass_hit |-> (count_q == 2'd0));

endmodule

// File: tb/tb_ysyx_25010008_fetch_ctrl.sv
// Directed bench for ysyx_25010008_fetch_ctrl: scoreboard queues for requests and decode handoffs.
module tb_ysyx_25010008_fetch_ctrl;

    logic        clock = 1'b0;
    logic        reset;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        fetch_valid;
    logic        fetch_ready;
    logic [31:0] fetch_pc;
    logic [31:0] fetch_inst;
    logic        exu_redirect;
    logic [31:0] exu_npc;
    logic        clear_pipeline;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
    } exp_t;

    exp_t        exp_fetch[$];
    logic [31:0] exp_req[$];
    longint      req_times[$];

    int vectors     = 0;
    int miscompares = 0;
    int req_seen    = 0;
    int req_target  = 0;
    int fetch_seen  = 0;
    int fetch_target = 0;

    logic        auto_rsp;
    logic        pend;
    logic [31:0] pend_addr;

    ysyx_25010008_fetch_ctrl dut (
        .clock          (clock),
        .reset          (reset),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .fetch_valid    (fetch_valid),
        .fetch_ready    (fetch_ready),
        .fetch_pc       (fetch_pc),
        .fetch_inst     (fetch_inst),
        .exu_redirect   (exu_redirect),
        .exu_npc        (exu_npc),
        .clear_pipeline (clear_pipeline)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Monitor: compares every accepted request and every decode handoff against the queues.
    initial begin : monitor
        exp_t e;
        logic [31:0] a;
        forever begin
            @(negedge clock);
            if (reset && imem_req_valid && imem_req_ready) begin
                req_seen++;
                req_times.push_back($time);
                if (exp_req.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL req_unexpected: got addr %h, expected no request", imem_req_addr);
                end else begin
                    a = exp_req.pop_front();
                    check("req_addr", imem_req_addr, a);
                end
            end
            if (reset && fetch_valid && fetch_ready && !exu_redirect) begin
                fetch_seen++;
                if (exp_fetch.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL fetch_unexpected: got pc %h inst %h, expected nothing", fetch_pc, fetch_inst);
                end else begin
                    e = exp_fetch.pop_front();
                    check("fetch_pc", fetch_pc, e.pc);
                    check("fetch_inst", fetch_inst, e.inst);
                end
            end
        end
    end

    task automatic push_req(input logic [31:0] addr);
        exp_req.push_back(addr);
        req_target++;
    endtask

    task automatic push_fetch(input logic [31:0] pc, input logic [31:0] inst);
        exp_t e;
        e.pc   = pc;
        e.inst = inst;
        exp_fetch.push_back(e);
        fetch_target++;
    endtask

    task automatic flush_sb();
        fetch_target -= exp_fetch.size();
        exp_fetch.delete();
    endtask

    // Memory model: answers one cycle after acceptance with data = ~addr.
    task automatic mem_drive();
        if (auto_rsp) begin
            imem_rsp_valid = pend;
            imem_rsp_data  = pend ? ~pend_addr : 32'h0;
            pend = 1'b0;
        end
    endtask

    task automatic tick();
        @(negedge clock);
        if (reset && imem_req_valid && imem_req_ready) begin
            pend      = 1'b1;
            pend_addr = imem_req_addr;
        end
        @(posedge clock);
        #1;
    endtask

    task automatic step();
        mem_drive();
        tick();
    endtask

    task automatic wait_req();
        for (int i = 0; i < 100 && req_seen < req_target; i++) step();
        check("wait_req_count", 32'(req_seen), 32'(req_target));
    endtask

    task automatic wait_fetch();
        for (int i = 0; i < 100 && fetch_seen < fetch_target; i++) step();
        check("wait_fetch_count", 32'(fetch_seen), 32'(fetch_target));
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin : main
        reset          = 1'b0;
        imem_req_ready = 1'b1;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
        fetch_ready    = 1'b1;
        exu_redirect   = 1'b0;
        exu_npc        = 32'h0;
        auto_rsp       = 1'b1;
        pend           = 1'b0;
        pend_addr      = 32'h0;

        // Reset values, and clear_pipeline following exu_redirect in reset.
        #2;
        check("rst_req_valid", {31'b0, imem_req_valid}, 32'd0);
        check("rst_fetch_valid", {31'b0, fetch_valid}, 32'd0);
        check("rst_fetch_pc", fetch_pc, 32'h0);
        check("rst_fetch_inst", fetch_inst, 32'h0);
        check("rst_clear_low", {31'b0, clear_pipeline}, 32'd0);
        exu_redirect = 1'b1;
        #1;
        check("rst_clear_follows", {31'b0, clear_pipeline}, 32'd1);
        exu_redirect = 1'b0;
        @(posedge clock);
        @(posedge clock);
        #1;
        reset = 1'b1;
        tick();
        check("first_req_valid", {31'b0, imem_req_valid}, 32'd1);
        check("first_req_addr", imem_req_addr, 32'h8000_0000);

        // In-order fetch with a 1-cycle memory.
        push_req(32'h8000_0000);
        push_req(32'h8000_0004);
        push_req(32'h8000_0008);
        push_fetch(32'h8000_0000, 32'h7FFF_FFFF);
        push_fetch(32'h8000_0004, 32'h7FFF_FFFB);
        push_fetch(32'h8000_0008, 32'h7FFF_FFF7);
        wait_req();
        imem_req_ready = 1'b0;
        check("req_spacing", 32'(req_times[2] - req_times[1]), 32'd20);
        wait_fetch();

        // Back-pressure: queue fills, requests stop; one pop yields exactly one request.
        fetch_ready    = 1'b0;
        imem_req_ready = 1'b1;
        push_req(32'h8000_000C);
        push_req(32'h8000_0010);
        push_fetch(32'h8000_000C, 32'h7FFF_FFF3);
        push_fetch(32'h8000_0010, 32'h7FFF_FFEF);
        push_fetch(32'h8000_0014, 32'h7FFF_FFEB);
        wait_req();
        step();
        for (int i = 0; i < 3; i++) begin
            check("full_no_req", {31'b0, imem_req_valid}, 32'd0);
            check("full_valid", {31'b0, fetch_valid}, 32'd1);
            step();
        end
        push_req(32'h8000_0014);
        fetch_ready = 1'b1;
        step();
        fetch_ready = 1'b0;
        for (int i = 0; i < 6; i++) step();
        check("one_new_req", 32'(req_seen), 32'(req_target));
        check("refull_no_req", {31'b0, imem_req_valid}, 32'd0);
        imem_req_ready = 1'b0;
        fetch_ready    = 1'b1;
        wait_fetch();

        // Redirect while waiting: flush, in-flight 0xDEADBEEF discarded, restart at 0x80000100.
        fetch_ready    = 1'b0;
        imem_req_ready = 1'b1;
        push_req(32'h8000_0018);
        push_req(32'h8000_001C);
        push_fetch(32'h8000_0018, 32'h7FFF_FFE7);
        wait_req();
        auto_rsp = 1'b0;
        pend     = 1'b0;
        check("pre_redirect_valid", {31'b0, fetch_valid}, 32'd1);
        check("pre_redirect_pc", fetch_pc, 32'h8000_0018);
        exu_redirect = 1'b1;
        exu_npc      = 32'h8000_0103;
        #1;
        check("clear_same_cycle", {31'b0, clear_pipeline}, 32'd1);
        tick();
        exu_redirect = 1'b0;
        flush_sb();
        check("flush_valid_drop", {31'b0, fetch_valid}, 32'd0);
        check("clear_released", {31'b0, clear_pipeline}, 32'd0);
        check("wait_no_req", {31'b0, imem_req_valid}, 32'd0);
        fetch_ready    = 1'b1;
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'hDEAD_BEEF;
        tick();
        imem_rsp_valid = 1'b0;
        auto_rsp       = 1'b1;
        check("redir_req_valid", {31'b0, imem_req_valid}, 32'd1);
        check("redir_req_addr", imem_req_addr, 32'h8000_0100);
        push_req(32'h8000_0100);
        push_fetch(32'h8000_0100, 32'h7FFF_FEFF);
        wait_req();
        imem_req_ready = 1'b0;
        wait_fetch();

        // Redirect in the same cycle as a response: response dropped, next one delivered.
        push_req(32'h8000_0104);
        imem_req_ready = 1'b1;
        wait_req();
        imem_req_ready = 1'b0;
        exu_redirect   = 1'b1;
        exu_npc        = 32'h8000_0200;
        step();
        exu_redirect = 1'b0;
        flush_sb();
        check("coinc_valid_low", {31'b0, fetch_valid}, 32'd0);
        check("coinc_next_req", {31'b0, imem_req_valid}, 32'd1);
        check("coinc_next_addr", imem_req_addr, 32'h8000_0200);
        push_req(32'h8000_0200);
        push_fetch(32'h8000_0200, 32'h7FFF_FDFF);
        imem_req_ready = 1'b1;
        wait_req();
        imem_req_ready = 1'b0;
        wait_fetch();

        // Redirect against a held request: address frozen, its response dropped, then the new PC.
        check("held_addr_0", imem_req_addr, 32'h8000_0204);
        exu_redirect = 1'b1;
        exu_npc      = 32'h8000_0300;
        step();
        exu_redirect = 1'b0;
        flush_sb();
        for (int i = 1; i < 3; i++) begin
            check("held_valid", {31'b0, imem_req_valid}, 32'd1);
            check("held_addr", imem_req_addr, 32'h8000_0204);
            step();
        end
        push_req(32'h8000_0204);
        push_req(32'h8000_0300);
        push_fetch(32'h8000_0300, 32'h7FFF_FCFF);
        imem_req_ready = 1'b1;
        wait_req();
        imem_req_ready = 1'b0;
        wait_fetch();

        // Reset during WAIT, then a late response after release.
        push_req(32'h8000_0304);
        imem_req_ready = 1'b1;
        wait_req();
        auto_rsp = 1'b0;
        pend     = 1'b0;
        reset    = 1'b0;
        #1;
        check("midrst_req_valid", {31'b0, imem_req_valid}, 32'd0);
        check("midrst_fetch_valid", {31'b0, fetch_valid}, 32'd0);
        check("midrst_fetch_pc", fetch_pc, 32'h0);
        flush_sb();
        tick();
        tick();
        reset          = 1'b1;
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'hDEAD_BEEF;
        tick();
        imem_rsp_valid = 1'b0;
        auto_rsp       = 1'b1;
        check("late_rsp_ignored", {31'b0, fetch_valid}, 32'd0);
        check("post_rst_req", {31'b0, imem_req_valid}, 32'd1);
        check("post_rst_addr", imem_req_addr, 32'h8000_0000);
        push_req(32'h8000_0000);
        push_fetch(32'h8000_0000, 32'h7FFF_FFFF);
        wait_req();
        imem_req_ready = 1'b0;

        // Response-to-fetch latency with an empty queue and decode ready.
        mem_drive();
        #1;
`ifdef YSYX_25010008_FETCH_BYPASS_EN
        check("bypass_same_cycle", {31'b0, fetch_valid}, 32'd1);
        tick();
        check("bypass_not_pushed", {31'b0, fetch_valid}, 32'd0);
`else
        check("nobypass_same_cycle", {31'b0, fetch_valid}, 32'd0);
        tick();
        check("nobypass_next_cycle", {31'b0, fetch_valid}, 32'd1);
`endif
        wait_fetch();

        check("req_queue_empty", 32'(exp_req.size()), 32'd0);
        check("fetch_queue_empty", 32'(exp_fetch.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
